board_ctrl: RTL and testbench



---
 rtl/breakout_pkg.sv | 17 +
 rtl/board_ctrl.sv | 87 ++++++++
 tb/tb_board_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared geometry and FSM encoding for the breakout game so that display, paddle
// and future ball/collision logic agree on screen dimensions and state codes.
package breakout_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BOARD_W  = 64;
  localparam int unsigned BOARD_H  = 8;
  localparam int unsigned COORD_W  = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHoldL = 2'd1,
    StHoldR = 2'd2
  } board_state_e;

endpackage

// File: rtl/board_ctrl.sv
// Paddle position generator: moves the board once per frame from the button levels,
// switching to a faster step after a button has been held for HOLD_FRAMES frames.
module board_ctrl #(
  parameter int unsigned SCREEN_W    = breakout_pkg::SCREEN_W,
  parameter int unsigned BOARD_W     = breakout_pkg::BOARD_W,
  parameter int unsigned BOARD_Y     = 296,
  parameter int unsigned X_INIT      = 288,
  parameter int unsigned SLOW_STEP   = 2,
  parameter int unsigned FAST_STEP   = 6,
  parameter int unsigned HOLD_FRAMES = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_tick,
  input  logic                              left,
  input  logic                              right,
  output logic [breakout_pkg::COORD_W-1:0]  board_x,
  output logic [breakout_pkg::COORD_W-1:0]  board_y,
  output logic                              moving,
  output logic                              fast
);
  import breakout_pkg::*;

  localparam int unsigned CntW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_FRAMES);
  localparam logic signed [COORD_W:0] XMax = (COORD_W + 1)'(SCREEN_W - BOARD_W);

  board_state_e        state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [COORD_W-1:0]  x_q, x_d;

  logic                go_left, go_right;
  board_state_e        target;
  logic signed [COORD_W:0] step, nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= COORD_W'(X_INIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    go_left  = left & ~right;
    go_right = right & ~left;
    target   = go_left ? StHoldL : StHoldR;
    step     = '0;
    nx       = '0;

    if (frame_tick) begin
      if (go_left || go_right) begin
        state_d = target;
        // A fresh hold or a reversal restarts the count, so reversals begin slow.
        if (state_q == target) begin
          cnt_d = (cnt_q >= HoldMax) ? HoldMax : cnt_q + 1'b1;
        end else begin
          cnt_d = CntW'(1);
        end
        step = (cnt_d >= HoldMax) ? (COORD_W + 1)'(FAST_STEP) : (COORD_W + 1)'(SLOW_STEP);
        if (go_left) begin
          nx  = $signed({1'b0, x_q}) - step;
          x_d = (nx < 0) ? '0 : nx[COORD_W-1:0];
        end else begin
          nx  = $signed({1'b0, x_q}) + step;
          x_d = (nx > XMax) ? XMax[COORD_W-1:0] : nx[COORD_W-1:0];
        end
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  assign board_x = x_q;
  assign board_y = COORD_W'(BOARD_Y);
  assign moving  = (state_q != StIdle);
  assign fast    = moving && (cnt_q >= HoldMax);

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: a behavioural paddle model queues expected outputs
// per stimulus cycle; they are popped and compared on the following falling edge.
module tb_board_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [9:0] board_x, board_y;
  logic       moving, fast;

  board_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .left       (left),
    .right      (right),
    .board_x    (board_x),
    .board_y    (board_y),
    .moving     (moving),
    .fast       (fast)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int mov;
    int fst;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: 0 idle, 1 hold left, 2 hold right.
  int m_x = 288, m_st = 0, m_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 288; m_st = 0; m_cnt = 0;
  endtask

  task automatic model_tick(input logic l, input logic r);
    int tgt, stp;
    if (l != r) begin
      tgt = l ? 1 : 2;
      if (m_st == tgt) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      else m_cnt = 1;
      m_st = tgt;
      stp = (m_cnt >= 15) ? 6 : 2;
      if (l) m_x = (m_x - stp < 0) ? 0 : m_x - stp;
      else   m_x = (m_x + stp > 576) ? 576 : m_x + stp;
    end else begin
      m_st = 0; m_cnt = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.x = m_x; e.mov = (m_st != 0); e.fst = (m_st != 0) && (m_cnt >= 15);
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_x"}, int'(board_x), e.x);
    check({tag, "_moving"}, int'(moving), e.mov);
    check({tag, "_fast"}, int'(fast), e.fst);
    check({tag, "_y"}, int'(board_y), 296);
  endtask

  // One cycle of stimulus driven at negedge; result compared one cycle later.
  task automatic cyc(input string tag, input logic tick, input logic l, input logic r);
    left = l; right = r; frame_tick = tick;
    if (tick) model_tick(l, r);
    push_exp();
    @(negedge clk);
    frame_tick = 1'b0;
    compare(tag);
  endtask

  task automatic ticks(input string tag, input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, l, r);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    push_exp();
    compare("reset");
    rst = 1'b0;
    @(negedge clk);

    ticks("no_btn", 5, 1'b0, 1'b0);

    ticks("right_slow", 14, 1'b0, 1'b1);
    check("x_after_14", int'(board_x), 316);
    cyc("right_fast15", 1'b1, 1'b0, 1'b1);
    check("x_after_15", int'(board_x), 322);
    check("fast_at_15", int'(fast), 1);

    // Reversal out of fast mode begins slow.
    ticks("right_more", 3, 1'b0, 1'b1);
    cyc("reverse", 1'b1, 1'b1, 1'b0);
    check("reverse_step", int'(board_x), 340 - 2);

    // Run to the left edge, then set up x = 4 and approach it slowly.
    ticks("left_run", 80, 1'b1, 1'b0);
    ticks("idle_a", 1, 1'b0, 1'b0);
    ticks("right_to4", 2, 1'b0, 1'b1);
    check("x_is_4", int'(board_x), 4);
    ticks("idle_b", 1, 1'b0, 1'b0);
    ticks("left_edge", 3, 1'b1, 1'b0);
    check("left_clamp", int'(board_x), 0);
    check("left_clamp_mov", int'(moving), 1);

    // Right edge: saturate, step back to 574, then push into the limit.
    ticks("right_run", 110, 1'b0, 1'b1);
    ticks("idle_c", 1, 1'b0, 1'b0);
    ticks("left_574", 1, 1'b1, 1'b0);
    ticks("idle_d", 1, 1'b0, 1'b0);
    ticks("right_edge", 3, 1'b0, 1'b1);
    check("right_clamp", int'(board_x), 576);

    // Both buttons idle the FSM; toggles between ticks are ignored.
    cyc("both", 1'b1, 1'b1, 1'b1);
    cyc("gap_hi", 1'b0, 1'b0, 1'b1);
    cyc("gap_lo", 1'b0, 1'b0, 1'b0);
    cyc("gap_hi2", 1'b0, 1'b0, 1'b1);
    cyc("tick_none", 1'b1, 1'b0, 1'b0);

    // Async reset while holding right at x = 400.
    ticks("idle_e", 1, 1'b0, 1'b0);
    ticks("left_back", 1, 1'b1, 1'b0);
    while (m_x > 300) ticks("left_home", 1, 1'b1, 1'b0);
    ticks("idle_f", 1, 1'b0, 1'b0);
    while (m_x != 288) begin
      if (m_x > 288) ticks("seek", 1, 1'b1, 1'b0);
      else ticks("seek", 1, 1'b0, 1'b1);
      ticks("seek_idle", 1, 1'b0, 1'b0);
    end
    ticks("to400", 28, 1'b0, 1'b1);
    check("x_400", int'(board_x), 400);
    left = 1'b0; right = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    compare("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc("post_rst", 1'b1, 1'b0, 1'b1);
    check("post_rst_x", int'(board_x), 290);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
